// File: rtl/led_serial_shifter.sv
// Parallel-to-serial driver for the external LED shift-register chain.
// Captures a word, shifts it out on sout/sclk at a programmable rate, then strobes EN.
module led_serial_shifter #(
  parameter int DATA_BITS       = 16,
  parameter int DATA_COUNT_BITS = 4,
  parameter int DIR             = 0,
  parameter int HALF_PERIOD     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  input  logic [DATA_BITS-1:0] PData,
  output logic                 sclk,
  output logic                 sout,
  output logic                 sclrn,
  output logic                 EN
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

  localparam logic [7:0]                 HALF_LAST = 8'(HALF_PERIOD - 1);
  localparam logic [DATA_COUNT_BITS-1:0] BIT_LAST  = DATA_COUNT_BITS'(DATA_BITS - 1);

  state_t                     state_q, state_d;
  logic [DATA_BITS-1:0]       shreg_q, shreg_d, shifted;
  logic [DATA_COUNT_BITS-1:0] bitcnt_q, bitcnt_d;
  logic [7:0]                 halfcnt_q, halfcnt_d;
  logic                       sclk_q, sclk_d;
  logic                       sout_q, sout_d;
  logic                       sclrn_q, sclrn_d;
  logic                       en_q, en_d;
  logic                       phase_end;

  function automatic logic first_bit(input logic [DATA_BITS-1:0] w);
    return (DIR != 0) ? w[0] : w[DATA_BITS-1];
  endfunction

  assign shifted   = (DIR != 0) ? (shreg_q >> 1) : (shreg_q << 1);
  assign phase_end = (halfcnt_q == HALF_LAST);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    halfcnt_d = halfcnt_q;
    sclk_d    = sclk_q;
    sout_d    = sout_q;
    sclrn_d   = 1'b1;
    en_d      = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        // The first edge after reset still sees sclrn low, so a held Start waits one edge.
        if (Start && sclrn_q) begin
          shreg_d   = PData;
          bitcnt_d  = '0;
          halfcnt_d = '0;
          sout_d    = first_bit(PData);
          state_d   = LOW;
        end
      end
      LOW: begin
        if (phase_end) begin
          sclk_d    = 1'b1;
          halfcnt_d = '0;
          state_d   = HIGH;
        end else begin
          halfcnt_d = halfcnt_q + 8'd1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sclk_d    = 1'b0;
          halfcnt_d = '0;
          if (bitcnt_q == BIT_LAST) begin
            en_d    = 1'b1;
            state_d = LATCH;
          end else begin
            // sout only moves with the falling sclk edge, centring it on the rising edge.
            shreg_d  = shifted;
            sout_d   = first_bit(shifted);
            bitcnt_d = bitcnt_q + 1'b1;
            state_d  = LOW;
          end
        end else begin
          halfcnt_d = halfcnt_q + 8'd1;
        end
      end
      LATCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      halfcnt_q <= '0;
      sclk_q    <= 1'b0;
      sout_q    <= 1'b0;
      sclrn_q   <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      halfcnt_q <= halfcnt_d;
      sclk_q    <= sclk_d;
      sout_q    <= sout_d;
      sclrn_q   <= sclrn_d;
      en_q      <= en_d;
    end
  end

  assign sclk  = sclk_q;
  assign sout  = sout_q;
  assign sclrn = sclrn_q;
  assign EN    = en_q;

endmodule

// File: tb/tb_led_serial_shifter.sv
// Directed bench for led_serial_shifter: default MSB-first, LSB-first and divided-rate instances.
module tb_led_serial_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [3];
  logic [15:0] pdata [3];
  wire  [2:0]  sclk_w, sout_w, sclrn_w, en_w;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-frame observations gathered by mon
  logic [31:0] word;
  int nrise, en_first, en_e2, en_cnt, overlap;
  int hi_min, hi_max, lo_min, lo_max;
  int rise_e [64];

  always #5 clk = ~clk;

  led_serial_shifter u_msb (
    .clk(clk), .rst(rst), .Start(start[0]), .PData(pdata[0]),
    .sclk(sclk_w[0]), .sout(sout_w[0]), .sclrn(sclrn_w[0]), .EN(en_w[0]));

  led_serial_shifter #(.DIR(1)) u_lsb (
    .clk(clk), .rst(rst), .Start(start[1]), .PData(pdata[1]),
    .sclk(sclk_w[1]), .sout(sout_w[1]), .sclrn(sclrn_w[1]), .EN(en_w[1]));

  led_serial_shifter #(.HALF_PERIOD(3)) u_div (
    .clk(clk), .rst(rst), .Start(start[2]), .PData(pdata[2]),
    .sclk(sclk_w[2]), .sout(sout_w[2]), .sclrn(sclrn_w[2]), .EN(en_w[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs(input int d);
    return 32'({sclk_w[d], sout_w[d], sclrn_w[d], en_w[d]});
  endfunction

  // Follows edges 1..n after a capture edge, optionally changing PData at edge chg_at.
  task automatic mon(input int d, input int n, input int chg_at, input logic [15:0] chg_val);
    logic ps, cs;
    int hi_run, lo_run;
    ps = 1'b0; hi_run = 0; lo_run = 1;
    word = '0; nrise = 0; en_first = -1; en_e2 = -1; en_cnt = 0; overlap = 0;
    hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
    for (int e = 1; e <= n; e++) begin
      tick();
      if (e == chg_at) pdata[d] = chg_val;
      cs = sclk_w[d];
      if (cs && !ps) begin
        word = {word[30:0], sout_w[d]};
        if (nrise < 64) rise_e[nrise] = e;
        nrise++;
        if (lo_run < lo_min) lo_min = lo_run;
        if (lo_run > lo_max) lo_max = lo_run;
        hi_run = 1;
      end else if (!cs && ps) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        lo_run = 1;
      end else if (cs) begin
        hi_run++;
      end else begin
        lo_run++;
      end
      if (en_w[d]) begin
        if (en_cnt == 0) en_first = e;
        else if (en_cnt == 1) en_e2 = e;
        en_cnt++;
        if (cs) overlap++;
      end
      ps = cs;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      pdata[i] = '0;
    end

    // Reset state and sclrn release
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("reset_outs%0d", i), outs(i), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("sclrn_release", 32'(sclrn_w), 32'h7);

    // Default MSB-first frame
    @(negedge clk);
    pdata[0] = 16'hA5C3; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("msb_first_bit", 32'(sout_w[0]), 32'h1);
    mon(0, 40, -1, 16'h0);
    check("msb_word", word, 32'h0000A5C3);
    check("msb_rises", nrise, 16);
    check("msb_rise0", rise_e[0], 1);
    check("msb_rise15", rise_e[15], 31);
    check("msb_en_edge", en_first, 32);
    check("msb_en_cnt", en_cnt, 1);
    check("msb_en_overlap", overlap, 0);

    // LSB-first order
    @(negedge clk);
    pdata[1] = 16'h0001; start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    check("lsb_first_bit", 32'(sout_w[1]), 32'h1);
    mon(1, 40, -1, 16'h0);
    check("lsb_word", word, 32'h00008000);
    check("lsb_rises", nrise, 16);
    check("lsb_en_edge", en_first, 32);

    // Divided rate, Start held so the second capture marks the frame length
    @(negedge clk);
    pdata[2] = 16'hFFFF; start[2] = 1'b1;
    tick();
    pdata[2] = 16'h0000;
    mon(2, 97, -1, 16'h0);
    check("div_hi_min", hi_min, 3);
    check("div_hi_max", hi_max, 3);
    check("div_lo_min", lo_min, 3);
    check("div_lo_max", lo_max, 3);
    check("div_rises", nrise, 16);
    check("div_en_edge", en_first, 96);
    check("div_en_cnt", en_cnt, 1);
    check("div_sout_97", 32'(sout_w[2]), 32'h1);
    tick();
    start[2] = 1'b0;
    check("div_recapture_98", 32'(sout_w[2]), 32'h0);

    // Continuous refresh with PData change mid-frame
    @(negedge clk);
    pdata[0] = 16'h00FF; start[0] = 1'b1;
    tick();
    check("cont_first_bit", 32'(sout_w[0]), 32'h0);
    mon(0, 67, 10, 16'hFF00);
    start[0] = 1'b0;
    check("cont_word", word, 32'h00FFFF00);
    check("cont_rises", nrise, 32);
    check("cont_en1", en_first, 32);
    check("cont_en2", en_e2, 66);
    check("cont_f2_rise0", rise_e[16], 35);

    // Reset mid-frame (HIGH of bit 5), Start held through release
    @(negedge clk);
    pdata[0] = 16'hFFFF; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (11) tick();
    check("abort_pre_sclk", 32'(sclk_w[0]), 32'h1);
    rst = 1'b1;
    #1;
    check("abort_outs", outs(0), 32'h0);
    pdata[0] = 16'h8000; start[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_hold_en", 32'(en_w[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rel_sclrn", 32'(sclrn_w[0]), 32'h1);
    check("rel_no_capture", 32'(sout_w[0]), 32'h0);
    check("rel_no_en", 32'(en_w[0]), 32'h0);
    tick();
    start[0] = 1'b0;
    check("rel_capture", 32'(sout_w[0]), 32'h1);
    mon(0, 40, -1, 16'h0);
    check("rel_word", word, 32'h00008000);
    check("rel_en_edge", en_first, 32);
    check("rel_en_cnt", en_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_serial_shifter.md
# led_serial_shifter

Parallel-to-serial shifter that drives the board's external LED shift-register chain. It sits directly downstream of the GPIO register block, which supplies the active-low LED pattern on `PData` and a refresh request on `Start`. The block captures a word, shifts it out on `sout`/`sclk` with a programmable bit rate, then pulses `EN` so the external register latches the new pattern. It also holds the external register cleared through `sclrn` during reset.

## Interface
- `DATA_BITS`, 16, width of the parallel word and the number of bits shifted per frame.
- `DATA_COUNT_BITS`, 4, bit-counter width; must satisfy 2^DATA_COUNT_BITS >= DATA_BITS.
- `DIR`, 0, shift order: 0 = MSB first, 1 = LSB first.
- `HALF_PERIOD`, 1, number of `clk` cycles per `sclk` phase (low or high); legal range 1..255.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Start`  in  1  level-sensitive refresh request, sampled only in IDLE.
- `PData`  in  DATA_BITS  parallel word; captured on the edge that leaves IDLE.
- `sclk`  out  1  serial clock to the external register, registered.
- `sout`  out  1  serial data, registered; stable for the whole high phase of `sclk`.
- `sclrn`  out  1  active-low clear of the external register, registered.
- `EN`  out  1  one-cycle latch strobe issued after the last bit.

## Operation
- Reset values: `sclk`=0, `sout`=0, `sclrn`=0, `EN`=0, state=IDLE, shift register=0, counters=0.
- `sclrn`: goes to 1 on the first `clk` rising edge after `rst` falls and stays 1 until the next reset. It is never asserted outside reset.
- Safe capture: GPIO updates `PData` on the falling edge of `clk`, so capture on the rising edge always sees stable data.
- States:
  - IDLE
    - `sclk`=0, `EN`=0, `sout` holds its last value.
    - If `Start`=1 and `sclrn`=1: load the shift register from `PData`, set bit count=0, drive `sout` with the first bit (bit DATA_BITS-1 if `DIR`=0, bit 0 if `DIR`=1), and go to LOW.
    - If `Start`=1 while `sclrn`=0 (the first edge after reset): ignore the request.
  - LOW
    - `sclk`=0.
    - After HALF_PERIOD cycles, set `sclk`=1 and go to HIGH.
  - HIGH
    - `sclk`=1.
    - After HALF_PERIOD cycles, set `sclk`=0.
    - If bit count = DATA_BITS-1, go to LATCH with `EN`=1.
    - Otherwise advance the shift register one position in `DIR` order, drive `sout` with the next bit, increment the bit count, and go to LOW.
  - LATCH
    - `EN`=1 for exactly one cycle, then `EN`=0 and go to IDLE.
- `Start` and `PData` changes outside IDLE are ignored; a frame always completes with the word captured at its start.
- If `Start` is held high, frames repeat back to back with one IDLE cycle between them.
- Reset during any state aborts the frame immediately: outputs go to their reset values and no `EN` pulse is produced.

## Timing
- Edge 0 is the IDLE edge that captures `PData`. With H = HALF_PERIOD:
  - Bit i (i = 0..DATA_BITS-1) is placed on `sout` at edge 2·H·i.
  - `sclk` rises at edge 2·H·i + H.
  - `sclk` falls at edge 2·H·(i+1).
  - `EN`=1 from edge 2·H·DATA_BITS to edge 2·H·DATA_BITS + 1.
  - IDLE is entered at edge 2·H·DATA_BITS + 1.
  - The earliest next capture is at edge 2·H·DATA_BITS + 2.
- Frame period = 2·H·DATA_BITS + 2 cycles; the defaults give 34 cycles.
- `sout` changes only together with a falling edge of `sclk` (or at capture), which gives H cycles of setup and H cycles of hold around each `sclk` rising edge.
- `EN` never overlaps `sclk`=1.

## Test plan
- Reset behaviour: assert `rst` mid-frame (during HIGH of bit 5) → all outputs take their reset values within the same cycle, no `EN` pulse follows, `sclrn` returns to 1 one edge after release, and a new `Start` is accepted on the following edge.
- Default MSB-first frame: `PData`=16'hA5C3, one-cycle `Start`, defaults → `sout` sampled at the 16 `sclk` rising edges reads 1010_0101_1100_0011, `EN` is high exactly at edge 32, and IDLE is reached at edge 33.
- LSB-first order: `DIR`=1, `PData`=16'h0001 → only the first shifted bit is 1, and 16 `sclk` pulses are produced.
- Divided rate: `HALF_PERIOD`=3, `PData`=16'hFFFF → `sclk` high and low phases each last exactly 3 cycles, `EN` is at edge 96, and the frame is 98 cycles.
- Continuous refresh and mid-frame update: hold `Start`=1, change `PData` from 16'h00FF to 16'hFF00 at edge 10 → frame 1 shifts 16'h00FF, frame 2 captures at edge 34 and shifts 16'hFF00, with exactly one IDLE cycle between frames.
- Start held through reset release: `Start`=1 while `rst` falls → no capture on the first edge (`sclrn`=0), capture on the second edge.
